width_adapter_scheduler: RTL and testbench

WIDTH_ADAPTER_SCHEDULER -- requirements
Module: width_adapter_scheduler

---
 rtl/jfpjc_pkg.sv | 15 +
 rtl/width_adapter_buffer.sv | 40 ++++
 rtl/width_adapter_scheduler.sv | 109 ++++++++++
 tb/tb_width_adapter_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jfpjc_pkg.sv
// Shared scheduler state encoding and width helper functions for the width adapter slice.
package jfpjc_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic int unsigned ratio_of(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/width_adapter_buffer.sv
// Word-to-chunk serializer: loads one word, then shifts it out LSB chunk first.
module width_adapter_buffer
    import jfpjc_pkg::*;
#(
    parameter int unsigned input_width  = 32,
    parameter int unsigned output_width = 4
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    data_in_valid,
    input  logic [input_width-1:0]  data_in,
    output logic                    data_out_valid,
    output logic [output_width-1:0] data_out
);

    localparam int unsigned RATIO = ratio_of(input_width, output_width);
    localparam int unsigned CNT_W = $clog2(RATIO + 1);

    logic [input_width-1:0] shift;
    logic [CNT_W-1:0]       remaining;

    // A new word only arrives as the last chunk of the previous one is leaving,
    // so a single shift register gives gap-free output without overrun.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            shift     <= '0;
            remaining <= '0;
        end else if (data_in_valid) begin
            shift     <= data_in;
            remaining <= CNT_W'(RATIO);
        end else if (remaining != '0) begin
            shift     <= shift >> output_width;
            remaining <= remaining - 1'b1;
        end
    end

    assign data_out       = shift[output_width-1:0];
    assign data_out_valid = (remaining != '0);

endmodule

// File: rtl/width_adapter_scheduler.sv
// Round-robin packet scheduler feeding a shared width adapter, paced to one word per RATIO cycles.
module width_adapter_scheduler
    import jfpjc_pkg::*;
#(
    parameter int unsigned input_width  = 32,
    parameter int unsigned output_width = 4,
    parameter int unsigned n_requesters = 3
) (
    input  logic                                  clock,
    input  logic                                  nreset,
    input  logic [n_requesters-1:0]               req_valid,
    input  logic [n_requesters-1:0]               req_last,
    input  logic [n_requesters*input_width-1:0]   req_data,
    output logic [n_requesters-1:0]               req_ready,
    output logic [id_width(n_requesters)-1:0]     grant_id,
    output logic                                  busy,
    output logic                                  packet_done,
    output logic                                  data_out_valid,
    output logic [output_width-1:0]               data_out
);

    localparam int unsigned RATIO  = ratio_of(input_width, output_width);
    localparam int unsigned ID_W   = id_width(n_requesters);
    localparam int unsigned PACE_W = $clog2(RATIO);

    if ((input_width % output_width) != 0 || RATIO < 2) begin : g_bad_params
        $error("width_adapter_scheduler: input_width must be a multiple of output_width with ratio >= 2");
    end

    logic [0:0]             state;
    logic [PACE_W-1:0]      pace_cnt;
    logic [input_width-1:0] word;
    logic                   word_valid;
    logic                   accept;
    logic                   found;
    logic [ID_W-1:0]        next_grant;
    logic [ID_W-1:0]        cand;

    always_comb begin
        req_ready = '0;
        if (state == ST_BUSY && pace_cnt == '0) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept = req_valid[grant_id] & req_ready[grant_id];
    assign busy   = (state == ST_BUSY);

    // Search starts one past the last grant, so the previous owner has lowest priority.
    always_comb begin
        next_grant = grant_id;
        found      = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= n_requesters; k++) begin
            cand = ID_W'((32'(grant_id) + k) % n_requesters);
            if (!found && req_valid[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= ST_IDLE;
            grant_id    <= ID_W'(n_requesters - 1);
            pace_cnt    <= '0;
            packet_done <= 1'b0;
            word        <= '0;
            word_valid  <= 1'b0;
        end else begin
            word_valid  <= accept;
            packet_done <= accept & req_last[grant_id];
            if (accept) begin
                word     <= req_data[grant_id*input_width +: input_width];
                pace_cnt <= PACE_W'(RATIO - 1);
            end else if (pace_cnt != '0) begin
                pace_cnt <= pace_cnt - 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_id <= next_grant;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept && req_last[grant_id]) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    width_adapter_buffer #(
        .input_width (input_width),
        .output_width(output_width)
    ) u_buffer (
        .clock         (clock),
        .nreset        (nreset),
        .data_in_valid (word_valid),
        .data_in       (word),
        .data_out_valid(data_out_valid),
        .data_out      (data_out)
    );

endmodule

// File: tb/tb_width_adapter_scheduler.sv
// Randomized bench for width_adapter_scheduler against a cycle-level transaction model.
module tb_width_adapter_scheduler;

    localparam int IW = 32;
    localparam int OW = 4;
    localparam int N  = 3;
    localparam int R  = IW / OW;
    localparam int GW = 2;

    logic            clock = 1'b0;
    logic            nreset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*IW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [GW-1:0]   grant_id;
    logic            busy;
    logic            packet_done;
    logic            data_out_valid;
    logic [OW-1:0]   data_out;

    width_adapter_scheduler #(
        .input_width (IW),
        .output_width(OW),
        .n_requesters(N)
    ) dut (
        .clock         (clock),
        .nreset        (nreset),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .packet_done   (packet_done),
        .data_out_valid(data_out_valid),
        .data_out      (data_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [OW-1:0] d;
    } chunk_t;

    // Pending words per requester; bit IW marks the last word of a packet.
    logic [IW:0] rq [N][$];
    chunk_t      expq[$];
    int          glog[$];
    int          acc_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    int owner, gid_m, last_acc, pd_at, prev_dut_acc;
    int gap_pct, pd_count, dov_cnt, run_len, max_run;
    int block [N];
    bit pause0, prev_busy;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = -1; gid_m = N - 1; last_acc = -1000; pd_at = -1; prev_dut_acc = -1;
        pd_count = 0; dov_cnt = 0; run_len = 0; max_run = 0; prev_busy = 0; pause0 = 0;
        expq.delete(); glog.delete(); acc_log.delete();
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            block[i] = 0;
        end
    endtask

    task automatic do_reset(input int hold);
        @(negedge clock);
        nreset = 1'b0;
        req_valid = '0;
        #1;
        check_value("rst_data_out_valid", data_out_valid, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_grant_id", grant_id, N - 1);
        check_value("rst_req_ready", req_ready, 0);
        check_value("rst_packet_done", packet_done, 0);
        model_reset();
        repeat (hold) @(negedge clock);
        nreset = 1'b1;
    endtask

    task automatic add_word(input int r, input logic [IW-1:0] w, input bit last);
        rq[r].push_back({last, w});
    endtask

    task automatic add_random_packet(input int r, input int nw);
        for (int k = 0; k < nw; k++) add_word(r, $urandom, k == nw - 1);
    endtask

    task automatic step();
        logic [N-1:0] exp_ready;
        logic [N-1:0] acc_dut;
        logic [IW:0]  w;
        chunk_t       c;
        int           o;
        @(negedge clock);
        if (expq.size() > 0 && expq[0].at == cyc) begin
            check_value("data_out_valid", data_out_valid, 1);
            check_value("data_out", data_out, expq[0].d);
            void'(expq.pop_front());
        end else begin
            check_value("data_out_idle", data_out_valid, 0);
        end
        while (expq.size() > 0 && expq[0].at < cyc) void'(expq.pop_front());
        check_value("packet_done", packet_done, cyc == pd_at);
        check_value("busy", busy, owner >= 0);
        check_value("grant_id", grant_id, gid_m);
        if (data_out_valid) begin
            dov_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (busy && !prev_busy) glog.push_back(int'(grant_id));
        prev_busy = busy;
        if (packet_done) pd_count++;

        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                w = rq[i][0];
                req_valid[i] = (block[i] == 0) && ($urandom_range(99) >= gap_pct);
                req_data[i*IW +: IW] = w[IW-1:0];
                req_last[i] = w[IW];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*IW +: IW] = $urandom;
                req_last[i] = $urandom_range(1);
            end
            if (block[i] > 0) block[i]--;
        end
        #1;
        exp_ready = '0;
        if (owner >= 0 && (cyc + 1 - last_acc) >= R) exp_ready[owner] = 1'b1;
        check_value("req_ready", req_ready, exp_ready);
        acc_dut = req_valid & req_ready;
        if (acc_dut != '0) begin
            if (prev_dut_acc >= 0) check_value("accept_spacing", (cyc + 1 - prev_dut_acc) >= R, 1);
            prev_dut_acc = cyc + 1;
        end

        if ((req_valid & exp_ready) != '0) begin
            o = owner;
            w = rq[o].pop_front();
            for (int j = 0; j < R; j++) begin
                c.at = cyc + 2 + j;
                c.d  = w[j*OW +: OW];
                expq.push_back(c);
            end
            last_acc = cyc + 1;
            acc_log.push_back(o);
            if (pause0 && o == 0) begin
                block[0] = 20;
                pause0 = 0;
            end
            if (w[IW]) begin
                pd_at = cyc + 1;
                owner = -1;
            end
        end else if (owner < 0 && req_valid != '0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (gid_m + k) % N;
                if (owner < 0 && req_valid[j]) begin
                    owner = j;
                    gid_m = j;
                end
            end
        end
    endtask

    function automatic bit pending();
        int left;
        left = 0;
        for (int i = 0; i < N; i++) left += rq[i].size();
        return (left > 0) || (expq.size() > 0) || (owner >= 0) || (cyc <= pd_at);
    endfunction

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while (pending() && t < budget) begin
            step();
            t++;
        end
        check_value(tag, pending(), 0);
    endtask

    initial begin
        nreset    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        gap_pct   = 0;
        model_reset();

        // Three requesters, two-word packets, back to back
        do_reset(3);
        for (int r = 0; r < N; r++) begin
            add_word(r, 32'h7654_3210, 1'b0);
            add_word(r, 32'hFEDC_BA98, 1'b1);
        end
        drain("s1_drain", 600);
        check_value("s1_packet_done_count", pd_count, 3);
        check_value("s1_grant_count", glog.size(), 3);
        check_value("s1_grant_first", glog.size() > 0 ? glog[0] : 99, 0);
        check_value("s1_grant_second", glog.size() > 1 ? glog[1] : 99, 1);
        check_value("s1_grant_third", glog.size() > 2 ? glog[2] : 99, 2);

        // Single requester, continuous four-word packet
        do_reset(2);
        add_random_packet(1, 4);
        drain("s2_drain", 400);
        check_value("s2_valid_cycles", dov_cnt, 32);
        check_value("s2_longest_run", max_run, 32);

        // Requester 0 stalls mid-packet while requester 2 waits
        do_reset(2);
        add_random_packet(0, 4);
        add_random_packet(2, 2);
        pause0 = 1;
        drain("s3_drain", 600);
        check_value("s3_accept_count", acc_log.size(), 6);
        check_value("s3_word4_owner", acc_log.size() > 3 ? acc_log[3] : 99, 0);
        check_value("s3_word5_owner", acc_log.size() > 4 ? acc_log[4] : 99, 2);

        // Reset after the first accepted word
        do_reset(2);
        for (int r = 0; r < N; r++) add_random_packet(r, 3);
        for (int t = 0; t < 100 && acc_log.size() == 0; t++) step();
        check_value("s4_one_accept", acc_log.size(), 1);
        step();
        do_reset(2);
        for (int r = N - 1; r >= 0; r--) add_random_packet(r, 2);
        drain("s4_drain", 800);
        check_value("s4_first_grant", glog.size() > 0 ? glog[0] : 99, 0);

        // Random packets and valid gaps
        for (int round = 0; round < 10; round++) begin
            do_reset(2);
            gap_pct = $urandom_range(60);
            for (int r = 0; r < N; r++) begin
                int npk;
                npk = $urandom_range(3);
                for (int p = 0; p < npk; p++) add_random_packet(r, $urandom_range(4, 1));
            end
            drain("rand_drain", 3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
